// File: rtl/theta_isogeny_stream_if.sv
// Handshake and data bundle between the isogeny-chain sequencer, the stream
// wrapper and the theta evaluation stage. master = sequencer/consumer side,
// slave = theta_isogeny_stream. No logic; signals only.
interface theta_isogeny_stream_if #(
  parameter int W     = 255,
  parameter int TAG_W = 4,
  parameter int CW    = 7
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [4*W-1:0]   tt1_a;
  logic [4*W-1:0]   tt1_b;
  logic [4*W-1:0]   tt2_a;
  logic [4*W-1:0]   tt2_b;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [4*W-1:0]   precomp_re;
  logic [4*W-1:0]   precomp_im;
  logic [4*W-1:0]   null_re;
  logic [4*W-1:0]   null_im;
  logic [CW-1:0]    credits;
  logic             busy;

  modport master (
    output flush, in_valid, in_tag, tt1_a, tt1_b, tt2_a, tt2_b, out_ready,
    input  in_ready, out_valid, out_tag, precomp_re, precomp_im, null_re, null_im,
           credits, busy
  );

  modport slave (
    input  flush, in_valid, in_tag, tt1_a, tt1_b, tt2_a, tt2_b, out_ready,
    output in_ready, out_valid, out_tag, precomp_re, precomp_im, null_re, null_im,
           credits, busy
  );
endinterface

// File: rtl/theta_isogeny_stream.sv
// Streaming wrapper around the fixed-latency theta isogeny core with tag tracking.
// Latency: LAT edges from accept to FIFO write; result visible right after that edge.
// Backpressure: credit based; in_ready drops when all DEPTH result slots are committed.

// Behavioural latency model of the compute core: same ports and latency as the
// real core, passing TT1 through as PRECOMP and TT2 as NULL_POINT. The wrapper's
// input registers are the core's input sample, so LATENCY-1 stages live here.
module theta_isogeny_compute #(
  parameter int W                             = 255,
  parameter int LATENCY_THETA_ISOGENY_COMPUTE = 48
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4*W-1:0] tt1_a,
  input  logic [4*W-1:0] tt1_b,
  input  logic [4*W-1:0] tt2_a,
  input  logic [4*W-1:0] tt2_b,
  output logic [4*W-1:0] precomp_re,
  output logic [4*W-1:0] precomp_im,
  output logic [4*W-1:0] null_re,
  output logic [4*W-1:0] null_im
);
  localparam int STG = LATENCY_THETA_ISOGENY_COMPUTE - 1;

  logic [16*W-1:0] pipe [STG];

  // free-running delay line; contents of idle cycles are don't-care downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STG; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {tt1_a, tt1_b, tt2_a, tt2_b};
      for (int i = 1; i < STG; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign {precomp_re, precomp_im, null_re, null_im} = pipe[STG-1];
endmodule

module theta_isogeny_stream #(
  parameter int W     = 255,
  parameter int LAT   = 48,
  parameter int DEPTH = 64,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  theta_isogeny_stream_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4*W-1:0]   pre_re;
    logic [4*W-1:0]   pre_im;
    logic [4*W-1:0]   nul_re;
    logic [4*W-1:0]   nul_im;
  } entry_t;

  logic             ready_en;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LAT-1:0]   sr_vld;
  logic [TAG_W-1:0] sr_tag [LAT];
  logic [4*W-1:0]   in_t1a, in_t1b, in_t2a, in_t2b;
  logic [4*W-1:0]   c_pre_re, c_pre_im, c_nul_re, c_nul_im;
  entry_t           mem [DEPTH];
  entry_t           head;
  logic             accept, pop, wr, in_rdy, out_vld;

  // ready only depends on registered state and flush, never on in_valid
  assign in_rdy  = ready_en && (credits != '0) && !bus.flush;
  assign out_vld = (count != '0) && !bus.flush;
  assign accept  = bus.in_valid && in_rdy;
  assign pop     = out_vld && bus.out_ready;
  assign wr      = sr_vld[LAT-1] && !bus.flush;

  // ready enable: in_ready may rise only from the first edge out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  // core input registers hold their last job between accepts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_t1a <= '0; in_t1b <= '0; in_t2a <= '0; in_t2b <= '0;
    end else if (accept) begin
      in_t1a <= bus.tt1_a; in_t1b <= bus.tt1_b;
      in_t2a <= bus.tt2_a; in_t2b <= bus.tt2_b;
    end
  end

  theta_isogeny_compute #(
    .W                             (W),
    .LATENCY_THETA_ISOGENY_COMPUTE (LAT)
  ) u_core (
    .clk        (clk),
    .reset      (~rst),
    .tt1_a      (in_t1a),
    .tt1_b      (in_t1b),
    .tt2_a      (in_t2a),
    .tt2_b      (in_t2b),
    .precomp_re (c_pre_re),
    .precomp_im (c_pre_im),
    .null_re    (c_nul_re),
    .null_im    (c_nul_im)
  );

  // valid/tag shadow of the core pipeline; flush kills every in-flight job
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_vld <= '0;
      for (int i = 0; i < LAT; i++) sr_tag[i] <= '0;
    end else begin
      sr_vld    <= bus.flush ? '0 : {sr_vld[LAT-2:0], accept};
      sr_tag[0] <= bus.in_tag;
      for (int i = 1; i < LAT; i++) sr_tag[i] <= sr_tag[i-1];
    end
  end

  // result storage; only the pointers and count need a reset
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= '{tag: sr_tag[LAT-1], pre_re: c_pre_re, pre_im: c_pre_im,
                             nul_re: c_nul_re, nul_im: c_nul_im};
  end

  // FIFO pointers wrap modulo DEPTH, which need not be a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
    end else begin
      if (wr)  wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // credits: one per free slot; taken on accept, returned on pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= CW'(DEPTH);
    end else if (bus.flush) begin
      credits <= CW'(DEPTH);
    end else begin
      case ({accept, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // outputs are forced to zero whenever no result is presented
  assign head           = out_vld ? mem[rd_ptr] : '0;
  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_vld;
  assign bus.out_tag    = head.tag;
  assign bus.precomp_re = head.pre_re;
  assign bus.precomp_im = head.pre_im;
  assign bus.null_re    = head.nul_re;
  assign bus.null_im    = head.nul_im;
  assign bus.credits    = credits;
  assign bus.busy       = (sr_vld != '0) || (count != '0);
endmodule

// File: tb/tb_theta_isogeny_stream.sv
// Bench for theta_isogeny_stream: random and directed jobs against a job-queue model.
// Model: each accepted job becomes visible LAT edges later, leaves in order on pop.
// Backpressure exercised by holding out_ready low until credits run out.
module tb_theta_isogeny_stream;
  localparam int W     = 255;
  localparam int LAT   = 48;
  localparam int DEPTH = 64;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef logic [4*W-1:0] bus_t;
  typedef struct {
    logic [TAG_W-1:0] tag;
    bus_t             t1a, t1b, t2a, t2b;
    int               due;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   started = 1'b0;
  job_t q[$];
  bus_t gv1_a1, gv1_b1, gv1_a2, gv1_b2, gv2_a1, gv2_b1, gv2_a2, gv2_b2;

  theta_isogeny_stream_if #(.W(W), .TAG_W(TAG_W), .CW(CW)) bus ();

  theta_isogeny_stream #(.W(W), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bus_t rnd_bus();
    logic [1023:0] t;
    for (int i = 0; i < 32; i++) t[i*32 +: 32] = $urandom;
    return t[4*W-1:0];
  endfunction

  function automatic logic [255:0] sl(input bus_t b, input int k);
    return {1'b0, b[k*W +: W]};
  endfunction

  // one clock: drive at negedge, compare against the model, then advance the model
  task automatic step(input logic v, input logic [TAG_W-1:0] tg, input bus_t a1, input bus_t b1,
                      input bus_t a2, input bus_t b2, input logic ordy, input logic fl,
                      output logic accepted);
    logic ex_rdy, ex_vld, acc, pp;
    job_t j;
    @(negedge clk);
    bus.in_valid = v; bus.in_tag = tg;
    bus.tt1_a = a1; bus.tt1_b = b1; bus.tt2_a = a2; bus.tt2_b = b2;
    bus.out_ready = ordy; bus.flush = fl;
    #1;
    ex_rdy = started && (q.size() < DEPTH) && !fl;
    ex_vld = (q.size() != 0) && !fl && (q[0].due <= cyc);
    check("in_ready",  {255'b0, bus.in_ready},  {255'b0, ex_rdy});
    check("out_valid", {255'b0, bus.out_valid}, {255'b0, ex_vld});
    check("credits",   256'(bus.credits),       256'(DEPTH - q.size()));
    check("busy",      {255'b0, bus.busy},      {255'b0, q.size() != 0});
    if (ex_vld) begin
      check("out_tag", 256'(bus.out_tag), 256'(q[0].tag));
      for (int k = 0; k < 4; k++) begin
        check($sformatf("precomp_re[%0d]", k), sl(bus.precomp_re, k), sl(q[0].t1a, k));
        check($sformatf("precomp_im[%0d]", k), sl(bus.precomp_im, k), sl(q[0].t1b, k));
        check($sformatf("null_re[%0d]", k),    sl(bus.null_re, k),    sl(q[0].t2a, k));
        check($sformatf("null_im[%0d]", k),    sl(bus.null_im, k),    sl(q[0].t2b, k));
      end
    end else begin
      check("out_tag_idle", 256'(bus.out_tag), 256'(0));
    end
    acc = v && ex_rdy;
    pp  = ex_vld && ordy;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      q.delete();
      started = 1'b0;
    end else begin
      if (fl) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          j.tag = tg; j.t1a = a1; j.t1b = b1; j.t2a = a2; j.t2b = b2; j.due = cyc + LAT;
          q.push_back(j);
        end
      end
      started = 1'b1;
    end
    accepted = acc;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, '0, ordy, 1'b0, a);
  endtask

  task automatic job(input logic [TAG_W-1:0] tg, input logic ordy, output logic a);
    step(1'b1, tg, rnd_bus(), rnd_bus(), rnd_bus(), rnd_bus(), ordy, 1'b0, a);
  endtask

  initial begin
    logic a;
    int   n, acc_cnt;
    bus.in_valid = 0; bus.in_tag = '0; bus.out_ready = 0; bus.flush = 0;
    bus.tt1_a = '0; bus.tt1_b = '0; bus.tt2_a = '0; bus.tt2_b = '0;
    gv1_a1 = rnd_bus(); gv1_b1 = rnd_bus(); gv1_a2 = rnd_bus(); gv1_b2 = rnd_bus();
    gv2_a1 = rnd_bus(); gv2_b1 = rnd_bus(); gv2_a2 = rnd_bus(); gv2_b2 = rnd_bus();

    // reset values while rst is held low
    idle(3, 1'b1);
    #2 rst = 1'b1;

    // single job, then back-to-back pair
    idle(6, 1'b1);
    step(1'b1, 4'h3, gv1_a1, gv1_b1, gv1_a2, gv1_b2, 1'b1, 1'b0, a);
    check("single_accept", {255'b0, a}, 256'(1));
    idle(LAT + 4, 1'b1);
    step(1'b1, 4'h1, gv1_a1, gv1_b1, gv1_a2, gv1_b2, 1'b1, 1'b0, a);
    step(1'b1, 4'h2, gv2_a1, gv2_b1, gv2_a2, gv2_b2, 1'b1, 1'b0, a);
    idle(LAT + 4, 1'b1);

    // backpressure: 70 offered with out_ready low, exactly DEPTH accepted
    n = 0;
    for (int c = 0; c < 70 + LAT + 10; c++) begin
      if (n < 70) begin
        job(4'(n % 16), 1'b0, a);
        if (a) n++;
      end else idle(1, 1'b0);
    end
    check("bp_accepted", 256'(n), 256'(DEPTH));
    idle(DEPTH + 5, 1'b1);

    // sustained throughput with wrap: every offer must be taken
    acc_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      job(4'($urandom_range(0, 15)), 1'b1, a);
      if (a) acc_cnt++;
    end
    check("thr_accepted", 256'(acc_cnt), 256'(300));
    idle(LAT + 4, 1'b1);

    // random valid / ready mix
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        job(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a);
      else idle(1, 1'($urandom_range(0, 1)));
    end
    idle(LAT + DEPTH + 5, 1'b1);

    // flush five edges after the last of ten accepts
    for (int i = 0; i < 10; i++) job(4'(i), 1'b1, a);
    idle(4, 1'b1);
    step(1'b0, '0, '0, '0, '0, '0, 1'b1, 1'b1, a);
    idle(LAT + 3, 1'b1);
    step(1'b1, 4'h9, gv1_a1, gv1_b1, gv1_a2, gv1_b2, 1'b1, 1'b0, a);
    idle(LAT + 4, 1'b1);

    // asynchronous reset between edges with 20 jobs outstanding
    for (int i = 0; i < 20; i++) job(4'(i), 1'b0, a);
    #1 rst = 1'b0;
    #1;
    check("arst_out_valid", {255'b0, bus.out_valid}, 256'(0));
    check("arst_in_ready",  {255'b0, bus.in_ready},  256'(0));
    check("arst_busy",      {255'b0, bus.busy},      256'(0));
    check("arst_credits",   256'(bus.credits),       256'(DEPTH));
    q.delete();
    started = 1'b0;
    #2 rst = 1'b1;
    idle(2, 1'b1);
    step(1'b1, 4'h7, gv2_a1, gv2_b1, gv2_a2, gv2_b2, 1'b1, 1'b0, a);
    idle(LAT + 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
